// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// One ALU execution lane behind the issue window's ALU select port. A selected
// op reads its operands from the physical register file (with a bypass from
// this lane's own write-back), executes, writes its result back and returns
// the commit/wake bundle to the issue window.
//
// Pipeline: RR (operand read) -> EX (execute) -> WB (registered outputs).
// Single-cycle ops commit two cycles after selection. MUL is iterative: it
// occupies EX for MUL_STEPS extra cycles while busy is high.
//
// Ports
//   clk, rst, flush       clock, synchronous active-high reset, pipeline flush
//   sl_en                 select valid
//   sl_operation          [5] src2 is the immediate, [4:0] opcode
//   sl_imm                immediate operand
//   sl_phydst             destination physical tag
//   sl_src1, sl_src2      source physical tags
//   sl_commit_window      issue-window slot of the op
//   busy                  MUL in progress, issuer must hold off
//   rf_raddr1/2           register-file read addresses (combinational)
//   rf_rdata1/2           register-file read data (combinational)
//   rf_we/waddr/wdata     register-file write port (tag 0 is never written)
//   alu_commit            one-cycle wake/commit strobe
//   alu_phydst            wake tag
//   wb_commit_window      issue-window slot to mark committable
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int CW_W      = 4,
  parameter int TAG_W     = 6,
  parameter int MUL_STEPS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             sl_en,
  input  logic [5:0]       sl_operation,
  input  logic [31:0]      sl_imm,
  input  logic [TAG_W-1:0] sl_phydst,
  input  logic [TAG_W-1:0] sl_src1,
  input  logic [TAG_W-1:0] sl_src2,
  input  logic [CW_W-1:0]  sl_commit_window,
  output logic             busy,
  output logic [TAG_W-1:0] rf_raddr1,
  output logic [TAG_W-1:0] rf_raddr2,
  input  logic [31:0]      rf_rdata1,
  input  logic [31:0]      rf_rdata2,
  output logic             rf_we,
  output logic [TAG_W-1:0] rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             alu_commit,
  output logic [TAG_W-1:0] alu_phydst,
  output logic [CW_W-1:0]  wb_commit_window
);

  localparam int SLICE_W = 32 / MUL_STEPS;
  localparam int STEP_W  = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [31:0] SLICE_MASK = 32'hFFFF_FFFF >> (32 - SLICE_W);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_NOR  = 5'd5;
  localparam logic [4:0] OP_SLT  = 5'd6;
  localparam logic [4:0] OP_SLTU = 5'd7;
  localparam logic [4:0] OP_SLL  = 5'd8;
  localparam logic [4:0] OP_SRL  = 5'd9;
  localparam logic [4:0] OP_SRA  = 5'd10;
  localparam logic [4:0] OP_LUI  = 5'd11;
  localparam logic [4:0] OP_MUL  = 5'd12;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_t;

  state_t state;

  // EX stage registers
  logic             ex_valid;
  logic [4:0]       ex_opcode;
  logic [31:0]      ex_op1;
  logic [31:0]      ex_op2;
  logic [TAG_W-1:0] ex_tag;
  logic [CW_W-1:0]  ex_cw;

  // Iterative multiplier state
  logic [STEP_W-1:0] mul_step;
  logic [31:0]       mul_acc;

  logic        accept;
  logic [31:0] byp1;
  logic [31:0] byp2;
  logic [31:0] alu_result;
  logic [4:0]  mul_shamt;
  logic [31:0] mul_slice;
  logic [31:0] mul_partial;
  logic [31:0] mul_sum;
  logic        mul_last;
  logic        wb_load;
  logic [31:0] wb_value;

  assign rf_raddr1 = sl_src1;
  assign rf_raddr2 = sl_src2;

  // A MUL sitting in EX while still IDLE is its entry cycle; selects there
  // and while busy are protocol violations and are silently dropped.
  assign accept = sl_en && !busy && !(ex_valid && (ex_opcode == OP_MUL));

  // The register file only sees our write at the end of the WB cycle, so a
  // same-cycle read of that tag must take the value from the write port.
  always_comb begin
    byp1 = (rf_we && (rf_waddr == sl_src1)) ? rf_wdata : rf_rdata1;
    byp2 = (rf_we && (rf_waddr == sl_src2)) ? rf_wdata : rf_rdata2;
  end

  always_comb begin
    alu_result = '0;
    case (ex_opcode)
      OP_ADD:  alu_result = ex_op1 + ex_op2;
      OP_SUB:  alu_result = ex_op1 - ex_op2;
      OP_AND:  alu_result = ex_op1 & ex_op2;
      OP_OR:   alu_result = ex_op1 | ex_op2;
      OP_XOR:  alu_result = ex_op1 ^ ex_op2;
      OP_NOR:  alu_result = ~(ex_op1 | ex_op2);
      OP_SLT:  alu_result = {31'b0, ($signed(ex_op1) < $signed(ex_op2))};
      OP_SLTU: alu_result = {31'b0, (ex_op1 < ex_op2)};
      OP_SLL:  alu_result = ex_op1 << ex_op2[4:0];
      OP_SRL:  alu_result = ex_op1 >> ex_op2[4:0];
      OP_SRA:  alu_result = $unsigned($signed(ex_op1) >>> ex_op2[4:0]);
      OP_LUI:  alu_result = {ex_op2[15:0], 16'h0000};
      default: alu_result = '0;
    endcase
  end

  // One multiplier slice per step; only the low 32 bits of each shifted
  // partial product can reach the low 32 bits of the full product.
  always_comb begin
    mul_shamt   = 5'(int'(mul_step) * SLICE_W);
    mul_slice   = (ex_op2 >> mul_shamt) & SLICE_MASK;
    mul_partial = (ex_op1 * mul_slice) << mul_shamt;
    mul_sum     = mul_acc + mul_partial;
    mul_last    = (mul_step == STEP_W'(MUL_STEPS - 1));
  end

  always_comb begin
    wb_load  = ((state == ST_IDLE) && ex_valid && (ex_opcode != OP_MUL)) ||
               ((state == ST_MUL) && mul_last);
    wb_value = (state == ST_MUL) ? mul_sum : alu_result;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state            <= ST_IDLE;
      busy             <= 1'b0;
      ex_valid         <= 1'b0;
      ex_opcode        <= '0;
      ex_op1           <= '0;
      ex_op2           <= '0;
      ex_tag           <= '0;
      ex_cw            <= '0;
      mul_step         <= '0;
      mul_acc          <= '0;
      rf_we            <= 1'b0;
      rf_waddr         <= '0;
      rf_wdata         <= '0;
      alu_commit       <= 1'b0;
      alu_phydst       <= '0;
      wb_commit_window <= '0;
    end else begin
      ex_valid <= accept;
      if (accept) begin
        ex_opcode <= sl_operation[4:0];
        ex_op1    <= byp1;
        ex_op2    <= sl_operation[5] ? sl_imm : byp2;
        ex_tag    <= sl_phydst;
        ex_cw     <= sl_commit_window;
      end

      // WB outputs are zero in every cycle without a commit.
      alu_commit       <= wb_load;
      alu_phydst       <= wb_load ? ex_tag : '0;
      wb_commit_window <= wb_load ? ex_cw : '0;
      rf_we            <= wb_load && (ex_tag != '0);
      rf_waddr         <= wb_load ? ex_tag : '0;
      rf_wdata         <= wb_load ? wb_value : '0;

      case (state)
        ST_IDLE: begin
          if (ex_valid && (ex_opcode == OP_MUL)) begin
            state    <= ST_MUL;
            busy     <= 1'b1;
            mul_step <= '0;
            mul_acc  <= '0;
          end
        end
        ST_MUL: begin
          mul_acc  <= mul_sum;
          mul_step <= mul_step + 1'b1;
          if (mul_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- One ALU execution lane on the far side of the issue window's ALU select port.
- Consumes the registered select bundle: enable, operation, immediate, physical destination/sources, commit window.
- Reads operands from the physical register file, executes, and writes the result back.
- Returns the commit/wake bundle that the issue window consumes: commit strobe, physical destination tag, commit-window index.
- Instantiated once per ALU lane (ALU0..ALU3).

Parameters:
- CW_W, 4, commit-window index width (issue window depth 16).
- TAG_W, 6, physical register tag width.
- MUL_STEPS, 4, MUL iterations; each step consumes 32/MUL_STEPS multiplier bits (must divide 32).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush, synchronous, same effect as rst
- sl_en  in  1  select valid
- sl_operation  in  6  [5]=src2 is imm, [4:0]=opcode
- sl_imm  in  32  immediate
- sl_phydst  in  TAG_W  destination tag
- sl_src1, sl_src2  in  TAG_W  source tags
- sl_commit_window  in  CW_W  issue-window slot
- busy  out  1  MUL in progress; issuer must not assert sl_en
- rf_raddr1, rf_raddr2  out  TAG_W  combinational register-file read addresses (= sl_src1/sl_src2)
- rf_rdata1, rf_rdata2  in  32  combinational read data
- rf_we  out  1  register-file write enable
- rf_waddr  out  TAG_W  write tag
- rf_wdata  out  32  write data
- alu_commit  out  1  wake/commit strobe
- alu_phydst  out  TAG_W  wake tag
- wb_commit_window  out  CW_W  slot to mark committable

Behaviour:
- Reset/flush: all registered outputs are 0 — busy, rf_we, rf_waddr, rf_wdata, alu_commit, alu_phydst, wb_commit_window. FSM returns to IDLE and all in-flight operations are discarded without commit. An sl_en in the same cycle as rst/flush is dropped.
- Stage RR (cycle T):
  - Accept when sl_en=1 and FSM is IDLE.
  - Operand capture: op1 = bypass(src1), op2 = imm if operation[5] else bypass(src2).
  - bypass(s) = rf_wdata if (rf_we and rf_waddr==s) else rf_rdata.
  - Capture op1/op2, opcode, tag and window into EX registers at end of T.
- Stage EX (cycle T+1): single-cycle opcodes compute and register the result into WB registers at end of T+1.
- Stage WB (cycle T+2):
  - alu_commit=1 for one cycle; alu_phydst and wb_commit_window valid.
  - rf_we = alu_commit AND (alu_phydst != 0); rf_waddr = tag, rf_wdata = result.
- Latency sl_en -> alu_commit: 2 cycles. Throughput: one op per cycle for non-MUL ops; back-to-back issues produce back-to-back commits.
- Opcodes (operation[4:0]):
  - 0 ADD, 1 SUB: 32-bit wrap, no overflow trap.
  - 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU: result 0/1.
  - 8 SLL, 9 SRL, 10 SRA: shift amount = op2[4:0].
  - 11 LUI: {op2[15:0],16'h0}.
  - 12 MUL: low 32 bits of unsigned product.
  - Others: result 0, still committed.
- MUL FSM:
  - IDLE -> MUL on MUL entering EX; busy=1 from the following cycle.
  - MUL step k (k = 0..MUL_STEPS-1): acc += op1 * op2 slice k, shifted to position k·(32/MUL_STEPS).
  - After the last step the result is loaded into WB and the FSM goes to IDLE. Commit occurs MUL_STEPS+1 cycles after the EX entry cycle.
  - busy deasserts in the commit cycle.
- sl_en while busy=1 or during the MUL EX-entry cycle is a protocol violation: the request is dropped and no commit is produced. Ops already in EX/WB complete normally.
- An op accepted in the cycle before a MUL reaches EX still completes ahead of the MUL, so commits stay in issue order per lane.
- Tag 0 ops commit (wake tag 0) but never write the register file.

Test Plan:
- Reset, then ADD sl_src1=5 (rf=10), sl_src2=6 (rf=32), phydst=9, window=3 at T -> at T+2: alu_commit=1, alu_phydst=9, wb_commit_window=3, rf_we=1, rf_wdata=42; all outputs 0 at T+3.
- Back-to-back ops: SUB imm (operation=6'h21, op1=5, imm=7) then SRA (op1=0x80000000, op2=4) -> consecutive commits: 0xFFFFFFFE, then 0xF8000000.
- Bypass: WB writes tag 9=42 while RR reads src1=9 with stale rf_rdata1=0 -> captured op1=42; ADD imm 1 commits 43.
- MUL 0x0001_0003 × 0x0000_0100 with MUL_STEPS=4 -> busy high 4 cycles; commit 5 cycles after EX entry with result 0x0100_0300; sl_en during busy produces no commit.
- Flush in the cycle an op sits in EX (and another in RR) -> no alu_commit and no rf_we within the next 6 cycles; busy=0.
- phydst=0 ADD -> alu_commit=1, alu_phydst=0, rf_we=0.
